sc_schedule_controller: RTL and testbench
=========================================

# sc_schedule_controller

Generates the successive-cancellation (SC) tree-traversal schedule for an N = 2^n polar decoder with 2^p processing elements. It sits directly upstream of the write-port controller and the PE array. For each cycle it drives the current stage index, the execution index within that stage, the f/g operation select, the decoded-bit index and the `decoder_busy` flag. Decoding runs from a start pulse to a done pulse.

## Interface
- `n`, default 3: log2 of code length N; legal range 2..10.
- `p`, default 1: log2 of PE count; legal range 1..n-1.
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  advance enable; while low, all state and outputs hold.
- `start`  input  1  start pulse; accepted only in IDLE, independent of `en`.
- `decoder_busy`  output  1  high from the first scheduled op through the last.
- `stage_index`  output  $clog2(n)  current stage; n-1 is the channel-LLR stage and 0 is the leaf stage.
- `exe_index`  output  n-p  remaining-cycle index within the current stage op; counts down to 1.
- `op_g`  output  1  0 = f function, 1 = g function.
- `bit_index`  output  n  index of the bit whose LLR path is being computed.
- `leaf`  output  1  high when `decoder_busy` is high and `stage_index` is 0.
- `done`  output  1  one-cycle pulse after the final op.

## Operation
- States: IDLE and RUN.
- IDLE values, also the reset values:
  - `stage_index` = n-1, `exe_index` = 2^(n-p-1), `op_g` = 0, `bit_index` = 0.
  - `decoder_busy`, `leaf` and `done` are 0.
- IDLE to RUN: on a `start` edge. Outputs load the bit-0 first op: stage n-1, exe 2^(n-p-1), f.
- An op at stage s lasts L(s) = 2^(s-p) cycles when s ≥ p, else 1 cycle. `exe_index` is loaded with L(s) at stage entry.
- On each edge in RUN with `en`=1:
  - If `exe_index` > 1: decrement `exe_index`.
  - Else if `stage_index` > 0: go to stage s-1, load `exe_index` = L(s-1), set `op_g` = 0.
  - Else (leaf cycle consumed):
    - If `bit_index` = N-1: go to IDLE and pulse `done`.
    - Otherwise: increment `bit_index` to i. With k = number of trailing zeros of i, load stage k, exe L(k), `op_g` = 1.
- Bit 0 always starts at stage n-1 with f. Every later bit starts with exactly one g op at stage ctz(i), then f ops down to stage 0.
- `start` while in RUN is ignored.
- `en`=0 in RUN freezes everything, including `leaf`.
- `exe_index` for s < p is exactly 1.
- Arithmetic: ctz is computed over n bits. L(s) is computed as 1 << (s-p) in an (n-p)-bit field; 2^(n-p-1) fits.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- `start` sampled at edge t: `decoder_busy`=1 from t+1.
- The op shown in a cycle executes in that cycle if `en`=1.
- `done`=1 for exactly one cycle, coincident with `decoder_busy`=0 and IDLE values.
- `start` is accepted in the `done` cycle. Back-to-back frames therefore have no dead cycle beyond `done`.
- Total RUN cycles with `en` held high = sum over bits of their op lengths. For n=3, p=1 this is 16.
- `rst` asserted mid-frame: immediately forces IDLE values. `done` is not pulsed.

## Configuration
- `SCHED_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 on an edge in RUN returns to IDLE values next cycle, with no `done` pulse.
  - `abort` takes priority over `en`.
  - `abort` in IDLE has no effect.
- `SCHED_ABORT_EN` undefined: no `abort` port; frames run to completion unless `rst` is asserted.

## Test plan
- **Reset:** assert `rst` → `stage_index`=2, `exe_index`=2, `decoder_busy`=0, `done`=0 (n=3, p=1).
- **Full frame, n=3, p=1, `en` held 1:**
  - Required (stage, exe, g) sequence: (2,2,0) (2,1,0) (1,1,0) (0,1,0) (0,1,1) (1,1,1) (0,1,0) (0,1,1) (2,2,1) (2,1,1) (1,1,0) (0,1,0) (0,1,1) (1,1,1) (0,1,0) (0,1,1).
  - `done` on cycle 17; `leaf` pulses 8 times with `bit_index` 0..7.
- **Stall:** toggle `en` pseudo-randomly → same op sequence as the full frame, each op held while `en`=0; `done` delayed by the number of `en`=0 cycles.
- **Start while busy:** pulse `start` mid-frame → ignored, sequence unchanged. `start` in the `done` cycle → new frame begins next cycle with (2,2,0).
- **Reset mid-frame:** assert `rst` at bit 4 → IDLE values, no `done`; the next `start` gives a full 16-cycle frame.
- **Abort, with `SCHED_ABORT_EN`:** `abort` at cycle 5 → `decoder_busy`=0 next cycle, no `done` pulse.

Source files
------------

// File: rtl/sc_schedule_controller.sv
// SC polar-decoder tree-traversal scheduler: per-cycle stage / exe / f-g / bit index for N=2^n, 2^p PEs.
// Optional `abort` input is compiled in when SCHED_ABORT_EN is defined.
module sc_schedule_controller #(
  parameter int n = 3,
  parameter int p = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
`ifdef SCHED_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   decoder_busy,
  output logic [$clog2(n)-1:0]   stage_index,
  output logic [n-p-1:0]         exe_index,
  output logic                   op_g,
  output logic [n-1:0]           bit_index,
  output logic                   leaf,
  output logic                   done
);

  localparam int SW = $clog2(n);
  localparam int EW = n - p;
  localparam int BW = n;
  localparam logic [SW-1:0] STAGE_TOP = SW'(n - 1);
  localparam logic [EW-1:0] EXE_TOP   = EW'(1 << (n - p - 1));
  localparam logic [BW-1:0] BIT_LAST  = {BW{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [EW-1:0]   exe_q, exe_d;
  logic            g_q, g_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            done_q, done_d;
  logic            leaf_q, leaf_d;
  logic            abort_w;
  logic            last_op;
  logic [BW-1:0]   nxt_bit;

`ifdef SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Op length at stage s: 2^(s-p) cycles once the stage is wider than the PE array, else one.
  function automatic logic [EW-1:0] op_len(input logic [SW-1:0] s);
    int si;
    si = int'(s);
    if (si >= p) return EW'(1 << (si - p));
    else         return EW'(1);
  endfunction

  function automatic logic [SW-1:0] ctz(input logic [BW-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int k = BW - 1; k >= 0; k--)
      if (v[k]) r = SW'(k);
    return r;
  endfunction

  assign last_op = (exe_q == EW'(1)) && (stage_q == '0) && (bit_q == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= STAGE_TOP;
      exe_q   <= EXE_TOP;
      g_q     <= 1'b0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      leaf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      exe_q   <= exe_d;
      g_q     <= g_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      leaf_q  <= leaf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort_w)            state_d = IDLE;
        else if (en && last_op) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE values coincide with the first op of bit 0, so a start needs no separate load.
  always_comb begin
    stage_d = stage_q;
    exe_d   = exe_q;
    g_d     = g_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    nxt_bit = bit_q + BW'(1);
    if (state_q == IDLE || abort_w) begin
      stage_d = STAGE_TOP;
      exe_d   = EXE_TOP;
      g_d     = 1'b0;
      bit_d   = '0;
    end else if (en) begin
      if (exe_q > EW'(1)) begin
        exe_d = exe_q - EW'(1);
      end else if (stage_q != '0) begin
        stage_d = stage_q - SW'(1);
        exe_d   = op_len(stage_q - SW'(1));
        g_d     = 1'b0;
      end else if (bit_q == BIT_LAST) begin
        stage_d = STAGE_TOP;
        exe_d   = EXE_TOP;
        g_d     = 1'b0;
        bit_d   = '0;
        done_d  = 1'b1;
      end else begin
        bit_d   = nxt_bit;
        stage_d = ctz(nxt_bit);
        exe_d   = op_len(ctz(nxt_bit));
        g_d     = 1'b1;
      end
    end
    leaf_d = (state_d == RUN) && (stage_d == '0);
  end

  assign decoder_busy = (state_q == RUN);
  assign stage_index  = stage_q;
  assign exe_index    = exe_q;
  assign op_g         = g_q;
  assign bit_index    = bit_q;
  assign leaf         = leaf_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sc_schedule_controller.sv
// Bench for sc_schedule_controller (n=3, p=1): reference schedule built from the SC traversal rules.
module tb_sc_schedule_controller;

  localparam int N_LOG = 3;
  localparam int P_LOG = 1;
  localparam int NBITS = 1 << N_LOG;

  logic clk = 1'b0;
  logic rst, en, start;
`ifdef SCHED_ABORT_EN
  logic abort;
`endif
  logic                    decoder_busy;
  logic [$clog2(N_LOG)-1:0] stage_index;
  logic [N_LOG-P_LOG-1:0]  exe_index;
  logic                    op_g;
  logic [N_LOG-1:0]        bit_index;
  logic                    leaf;
  logic                    done;

  int checks = 0;
  int errors = 0;

  int m_stage[$];
  int m_exe[$];
  int m_g[$];
  int m_bit[$];

  sc_schedule_controller #(.n(N_LOG), .p(P_LOG)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
`ifdef SCHED_ABORT_EN
    .abort(abort),
`endif
    .decoder_busy(decoder_busy), .stage_index(stage_index), .exe_index(exe_index),
    .op_g(op_g), .bit_index(bit_index), .leaf(leaf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(decoder_busy), 0);
    chk({tag, "_stage"}, 32'(stage_index), N_LOG - 1);
    chk({tag, "_exe"},   32'(exe_index), 1 << (N_LOG - P_LOG - 1));
    chk({tag, "_g"},     32'(op_g), 0);
    chk({tag, "_bit"},   32'(bit_index), 0);
    chk({tag, "_leaf"},  32'(leaf), 0);
  endtask

  // Every bit: one entry op (f at the root for bit 0, g at ctz(i) otherwise) then f ops down to the leaf.
  task automatic build_model();
    for (int i = 0; i < NBITS; i++) begin
      int s0, len;
      if (i == 0) s0 = N_LOG - 1;
      else begin
        s0 = 0;
        while (((i >> s0) & 1) == 0) s0++;
      end
      for (int s = s0; s >= 0; s--) begin
        len = (s >= P_LOG) ? (1 << (s - P_LOG)) : 1;
        for (int e = len; e >= 1; e--) begin
          m_stage.push_back(s);
          m_exe.push_back(e);
          m_g.push_back((i != 0 && s == s0) ? 1 : 0);
          m_bit.push_back(i);
        end
      end
    end
  endtask

  task automatic chk_op(input int idx);
    chk("busy",  32'(decoder_busy), 1);
    chk("stage", 32'(stage_index), m_stage[idx]);
    chk("exe",   32'(exe_index), m_exe[idx]);
    chk("op_g",  32'(op_g), m_g[idx]);
    chk("bit",   32'(bit_index), m_bit[idx]);
    chk("leaf",  32'(leaf), (m_stage[idx] == 0) ? 1 : 0);
    chk("done_low", 32'(done), 0);
  endtask

  // Assumes the first op of a frame is currently displayed.
  task automatic run_frame(input int stall_pct, input bit poke_start, input bit restart);
    int idx = 0;
    int guard = 0;
    int cycles = 0;
    int stalls = 0;
    while (idx < m_stage.size() && guard < 2000) begin
      chk_op(idx);
      en = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
      start = poke_start && ($urandom_range(0, 3) == 0);
      step();
      cycles++;
      if (en) idx++;
      else    stalls++;
      guard++;
    end
    chk("frame_complete", 32'(idx), 32'(m_stage.size()));
    chk("frame_cycles", 32'(cycles), 32'(m_stage.size() + stalls));
    start = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk_idle("done_cycle");
    if (restart) begin
      start = 1'b1;
      en = 1'b0;
      step();
      start = 1'b0;
      en = 1'b1;
    end else begin
      en = 1'b1;
      step();
      chk("done_cleared", 32'(done), 0);
      chk_idle("after_done");
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    start = 1'b0;
`ifdef SCHED_ABORT_EN
    abort = 1'b0;
`endif
    build_model();
    step();
    step();
    chk_idle("reset");
    chk("reset_done", 32'(done), 0);
    rst = 1'b0;
    step();
    chk_idle("post_reset");

    // Plain frame; start accepted with en low.
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    run_frame(0, 1'b0, 1'b0);

    // Stalled frame with start pokes, then back-to-back restart from the done cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    run_frame(40, 1'b1, 1'b1);
    run_frame(25, 1'b0, 1'b0);

    // Reset once bit 4 is reached.
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    begin
      int idx = 0;
      while (idx < m_stage.size() && m_bit[idx] != 4) begin
        chk_op(idx);
        step();
        idx++;
      end
      chk("reached_bit4", 32'(bit_index), 4);
    end
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_done", 32'(done), 0);
    step();
    chk("rst_hold_done", 32'(done), 0);
    rst = 1'b0;
    step();
    chk_idle("rst_release");
    start = 1'b1;
    step();
    start = 1'b0;
    run_frame(0, 1'b0, 1'b0);

`ifdef SCHED_ABORT_EN
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk_op(c);
      step();
    end
    chk_op(4);
    abort = 1'b1;
    en = 1'b0;
    step();
    abort = 1'b0;
    en = 1'b1;
    chk_idle("abort");
    chk("abort_done", 32'(done), 0);
    step();
    chk("abort_done_later", 32'(done), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_idle");
    start = 1'b1;
    step();
    start = 1'b0;
    run_frame(20, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
